// File: rtl/vga_raster_gen_if.sv
// Raster timing bundle from the timing generator to the paddle, ball and score blocks.
// The generator drives it through master; consumers read it through slave.
interface vga_raster_gen_if;
  logic       HSync;
  logic       VSync;
  logic [9:0] pixel;
  logic [8:0] line;
  logic       video_on;
  logic       pix_en;
  logic       frame_start;

  modport master (
    output HSync, VSync, pixel, line, video_on, pix_en, frame_start
  );

  modport slave (
    input HSync, VSync, pixel, line, video_on, pix_en, frame_start
  );
endinterface

// File: rtl/vga_raster_gen.sv
// Free-running 640x480 raster timing generator: a pixel-rate divider plus h/v counters,
// with every output registered and updated from the counters' next-state values.
module vga_raster_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input logic              clk,
  input logic              reset,
  vga_raster_gen_if.master rast
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [8:0] LINE_CLAMP = 9'(V_VISIBLE);

  logic [3:0] div_q, div_d;
  logic [9:0] hCnt_q, hCnt_d;
  logic [9:0] vCnt_q, vCnt_d;
  logic       tick, hWrap, vWrap;

  logic       hSync_q, hSync_d;
  logic       vSync_q, vSync_d;
  logic [9:0] pixel_q;
  logic [8:0] line_q, line_d;
  logic       videoOn_q, videoOn_d;
  logic       pixEn_q, pixEn_d;
  logic       frameStart_q, frameStart_d;

  always_comb begin
    tick   = (div_q == DIV_LAST);
    hWrap  = (hCnt_q == H_LAST);
    vWrap  = (vCnt_q == V_LAST);
    div_d  = tick ? 4'd0 : div_q + 4'd1;
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (tick) begin
      hCnt_d = hWrap ? 10'd0 : hCnt_q + 10'd1;
      if (hWrap) begin
        vCnt_d = vWrap ? 10'd0 : vCnt_q + 10'd1;
      end
    end
  end

  // Outputs follow the next counter values, so they change on the same edge as the counters
  // and simply hold whenever the counters hold.
  always_comb begin
    pixEn_d      = (div_d == DIV_LAST);
    frameStart_d = tick && hWrap && vWrap;
    hSync_d      = !((hCnt_d >= HS_START) && (hCnt_d < HS_END));
    vSync_d      = !((vCnt_d >= VS_START) && (vCnt_d < VS_END));
    videoOn_d    = (hCnt_d < H_VIS) && (vCnt_d < V_VIS);
    line_d       = (vCnt_d < V_VIS) ? vCnt_d[8:0] : LINE_CLAMP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q        <= 4'd0;
      hCnt_q       <= 10'd0;
      vCnt_q       <= 10'd0;
      hSync_q      <= 1'b1;
      vSync_q      <= 1'b1;
      pixel_q      <= 10'd0;
      line_q       <= 9'd0;
      videoOn_q    <= 1'b1;
      pixEn_q      <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      hSync_q      <= hSync_d;
      vSync_q      <= vSync_d;
      pixel_q      <= hCnt_d;
      line_q       <= line_d;
      videoOn_q    <= videoOn_d;
      pixEn_q      <= pixEn_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign rast.HSync       = hSync_q;
  assign rast.VSync       = vSync_q;
  assign rast.pixel       = pixel_q;
  assign rast.line        = line_q;
  assign rast.video_on    = videoOn_q;
  assign rast.pix_en      = pixEn_q;
  assign rast.frame_start = frameStart_q;

endmodule

// File: tb/tb_vga_raster_gen.sv
// Scoreboard bench: dutA runs the default 640x480 timing at CLK_DIV=2, dutB a tiny 15x10
// raster at CLK_DIV=1 so that whole frames fit in a short run.
module tb_vga_raster_gen;

  typedef struct {
    int edgeNo;
    int pixel;
    int line;
    bit hs;
    bit vs;
    bit von;
    bit fs;
    bit pe;
  } vec_t;

  logic clk = 1'b0;
  logic resetA = 1'b0;
  logic resetB = 1'b0;

  vga_raster_gen_if ifA ();
  vga_raster_gen_if ifB ();

  vga_raster_gen dutA (
    .clk  (clk),
    .reset(resetA),
    .rast (ifA)
  );

  vga_raster_gen #(
    .CLK_DIV(1),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dutB (
    .clk  (clk),
    .reset(resetB),
    .rast (ifB)
  );

  always #5 clk = ~clk;

  vec_t qA[$];
  vec_t qB[$];
  int   checks = 0;
  int   errors = 0;
  int   edgeA = 0;
  int   edgeB = 0;
  int   fsCountA = 0;
  int   fsCountB = 0;
  int   pixEnDropB = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit toB, input int k, input int px, input int ln,
                               input bit hs, input bit vs, input bit von, input bit fs,
                               input bit pe);
    vec_t v;
    v = '{k, px, ln, hs, vs, von, fs, pe};
    if (toB) qB.push_back(v);
    else     qA.push_back(v);
  endtask

  task automatic compareVec(input string tag, input vec_t e, input int px, input int ln,
                            input bit hs, input bit vs, input bit von, input bit fs,
                            input bit pe);
    string p;
    p = $sformatf("%s@%0d", tag, e.edgeNo);
    checkOutput({p, " pixel"}, px, e.pixel);
    checkOutput({p, " line"}, ln, e.line);
    checkOutput({p, " HSync"}, int'(hs), int'(e.hs));
    checkOutput({p, " VSync"}, int'(vs), int'(e.vs));
    checkOutput({p, " video_on"}, int'(von), int'(e.von));
    checkOutput({p, " frame_start"}, int'(fs), int'(e.fs));
    checkOutput({p, " pix_en"}, int'(pe), int'(e.pe));
  endtask

  // Monitor for dutA: counts edges since reset release and checks the scheduled vector.
  always begin
    vec_t e;
    @(posedge clk);
    #1;
    if (!resetA) begin
      edgeA = 0;
    end else begin
      edgeA++;
      if (ifA.frame_start) fsCountA++;
      while (qA.size() > 0 && qA[0].edgeNo < edgeA) begin
        e = qA.pop_front();
        checkOutput($sformatf("A missed edge %0d", e.edgeNo), edgeA, e.edgeNo);
      end
      if (qA.size() > 0 && qA[0].edgeNo == edgeA) begin
        e = qA.pop_front();
        compareVec("A", e, int'(ifA.pixel), int'(ifA.line), ifA.HSync, ifA.VSync,
                   ifA.video_on, ifA.frame_start, ifA.pix_en);
      end
    end
  end

  // Monitor for dutB, plus continuous pix_en and frame_start bookkeeping over its first 260 edges.
  always begin
    vec_t e;
    @(posedge clk);
    #1;
    if (!resetB) begin
      edgeB = 0;
    end else begin
      edgeB++;
      if (edgeB <= 260) begin
        if (ifB.frame_start) fsCountB++;
        if (!ifB.pix_en) pixEnDropB++;
      end
      while (qB.size() > 0 && qB[0].edgeNo < edgeB) begin
        e = qB.pop_front();
        checkOutput($sformatf("B missed edge %0d", e.edgeNo), edgeB, e.edgeNo);
      end
      if (qB.size() > 0 && qB[0].edgeNo == edgeB) begin
        e = qB.pop_front();
        compareVec("B", e, int'(ifB.pixel), int'(ifB.line), ifB.HSync, ifB.VSync,
                   ifB.video_on, ifB.frame_start, ifB.pix_en);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);

    // dutA, CLK_DIV=2: pixel count after edge k is k/2.
    //             edge  pixel line hs vs von fs pe
    applyStimulus(0,    1,   0, 0, 1, 1, 1, 0, 1);
    applyStimulus(0,    2,   1, 0, 1, 1, 1, 0, 0);
    applyStimulus(0, 1278, 639, 0, 1, 1, 1, 0, 0);
    applyStimulus(0, 1280, 640, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1310, 655, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1312, 656, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1503, 751, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1504, 752, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1598, 799, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1600,   0, 1, 1, 1, 1, 0, 0);
    applyStimulus(0, 2911, 655, 1, 1, 1, 0, 0, 1);
    applyStimulus(0, 2912, 656, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 3001, 700, 1, 0, 1, 0, 0, 1);

    // dutB, CLK_DIV=1, 15x10 raster: HSync low h=10..12, VSync low v=7..8, line clamps at 6.
    applyStimulus(1,   1,  1, 0, 1, 1, 1, 0, 1);
    applyStimulus(1,   7,  7, 0, 1, 1, 1, 0, 1);
    applyStimulus(1,   8,  8, 0, 1, 1, 0, 0, 1);
    applyStimulus(1,  10, 10, 0, 0, 1, 0, 0, 1);
    applyStimulus(1,  12, 12, 0, 0, 1, 0, 0, 1);
    applyStimulus(1,  13, 13, 0, 1, 1, 0, 0, 1);
    applyStimulus(1,  14, 14, 0, 1, 1, 0, 0, 1);
    applyStimulus(1,  15,  0, 1, 1, 1, 1, 0, 1);
    applyStimulus(1,  75,  0, 5, 1, 1, 1, 0, 1);
    applyStimulus(1,  82,  7, 5, 1, 1, 1, 0, 1);
    applyStimulus(1,  90,  0, 6, 1, 1, 0, 0, 1);
    applyStimulus(1, 104, 14, 6, 1, 1, 0, 0, 1);
    applyStimulus(1, 105,  0, 6, 1, 0, 0, 0, 1);
    applyStimulus(1, 119, 14, 6, 1, 0, 0, 0, 1);
    applyStimulus(1, 120,  0, 6, 1, 0, 0, 0, 1);
    applyStimulus(1, 135,  0, 6, 1, 1, 0, 0, 1);
    applyStimulus(1, 149, 14, 6, 1, 1, 0, 0, 1);
    applyStimulus(1, 150,  0, 0, 1, 1, 1, 1, 1);
    applyStimulus(1, 151,  1, 0, 1, 1, 1, 0, 1);
    applyStimulus(1, 254, 14, 6, 1, 1, 0, 0, 1);
    applyStimulus(1, 255,  0, 6, 1, 0, 0, 0, 1);

    resetA = 1'b1;
    resetB = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (qA.size() == 0 && qB.size() == 0) break;
    end
    checkOutput("timeout phase1 A", qA.size(), 0);
    checkOutput("timeout B", qB.size(), 0);

    // Mid-line reset on dutA (h=700, HSync low, pix_en high) must clear outputs without a clock edge.
    resetA = 1'b0;
    #1;
    checkOutput("rstImm pixel", int'(ifA.pixel), 0);
    checkOutput("rstImm line", int'(ifA.line), 0);
    checkOutput("rstImm HSync", int'(ifA.HSync), 1);
    checkOutput("rstImm VSync", int'(ifA.VSync), 1);
    checkOutput("rstImm video_on", int'(ifA.video_on), 1);
    checkOutput("rstImm pix_en", int'(ifA.pix_en), 0);
    checkOutput("rstImm frame_start", int'(ifA.frame_start), 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstHold pixel", int'(ifA.pixel), 0);
    checkOutput("rstHold pix_en", int'(ifA.pix_en), 0);

    @(negedge clk);
    applyStimulus(0,    1, 0, 0, 1, 1, 1, 0, 1);
    applyStimulus(0,    2, 1, 0, 1, 1, 1, 0, 0);
    applyStimulus(0,    3, 1, 0, 1, 1, 1, 0, 1);
    applyStimulus(0, 1600, 0, 1, 1, 1, 1, 0, 0);
    resetA = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (qA.size() == 0) break;
    end
    checkOutput("timeout phase2 A", qA.size(), 0);

    checkOutput("frame_start count A", fsCountA, 0);
    checkOutput("frame_start count B", fsCountB, 1);
    checkOutput("pix_en drops B", pixEnDropB, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
